// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity codes,
// oversampling constants and small combinational helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Ticks are numbered 1..OVS within a bit; majority votes use ticks 7, 8 and 9.
    localparam logic [4:0] OVS          = 5'd16;
    localparam logic [4:0] SAMPLE_EARLY = 5'd7;
    localparam logic [4:0] SAMPLE_MID   = 5'd8;
    localparam logic [4:0] SAMPLE_LATE  = 5'd9;

    function automatic logic [4:0] rxBitCount(input logic [1:0] sel, input logic [4:0] maxBits);
        case (sel)
            2'b00:   return 5'd5;
            2'b01:   return 5'd6;
            2'b10:   return 5'd7;
            2'b11:   return maxBits;
            default: return maxBits;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// 16x oversampling tick generator: one-clock Tick every BaudDiv+1 clocks.
module uart_rx_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DIV_W-1:0] BaudDiv,
    output logic             Tick
);

    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;

    // Down-counter reloads only on a tick so a new divisor never truncates a count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == '0) begin
            cnt_r  <= BaudDiv;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r - DIV_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign Tick = tick_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, frame FSM, shift register and output storage.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise one holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              DataTx,
    input  logic [DIV_W-1:0]  BaudDiv,
    input  logic [1:0]        DataBits,
    input  logic [1:0]        ParityType,
    input  logic              StopBits,
    output logic [DATA_W-1:0] DataOut,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              BreakFlag,
    output logic              DataValid,
    input  logic              DataReady,
    output logic              Overrun,
    output logic              Busy
);

    localparam logic [4:0] MAX_BITS = 5'(DATA_W);
    localparam int         ENT_W    = DATA_W + 3;

    logic              sync1_r, sync2_r, linePrev_r, fallEdge_s;
    logic              tick_s;
    rx_state_t         state_r, stateNext_s;
    logic [4:0]        cnt_r, thisTick_s, bitIdx_r;
    logic              stopIdx_r, v7_r, v8_r, maj_s;
    logic [DATA_W-1:0] data_r;
    logic              parAcc_r, anyOne_r, parErr_r, frameErr_r, stop1Low_r, brk_s;
    logic              lastBit_s, lastStop_s, parityOn_s, sampleTick_s, endTick_s;
    logic              busy_s, done_s, busy_r, done_r;
    logic              overrun_r, pop_s;
    logic [ENT_W-1:0]  entry_s;

    uart_rx_baud_gen #(.DIV_W(DIV_W)) uBaud (
        .Clock  (Clock),
        .Reset  (Reset),
        .BaudDiv(BaudDiv),
        .Tick   (tick_s)
    );

    // Two-flop synchroniser plus one more stage for falling-edge detection; idle high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            linePrev_r <= 1'b1;
        end else begin
            sync1_r    <= DataTx;
            sync2_r    <= sync1_r;
            linePrev_r <= sync2_r;
        end
    end

    // Edge-triggered rearm means a line stuck low after a break cannot restart a frame.
    assign fallEdge_s   = linePrev_r & ~sync2_r;
    assign thisTick_s   = cnt_r + 5'd1;
    assign sampleTick_s = tick_s && (thisTick_s == SAMPLE_LATE);
    assign endTick_s    = tick_s && (thisTick_s == OVS);
    assign maj_s        = majority3(v7_r, v8_r, sync2_r);
    assign parityOn_s   = (ParityType == PAR_ODD) || (ParityType == PAR_EVEN);
    assign lastBit_s    = (bitIdx_r == (rxBitCount(DataBits, MAX_BITS) - 5'd1));
    assign lastStop_s   = (StopBits == 1'b0) || stopIdx_r;
    assign brk_s        = ~anyOne_r & stop1Low_r;
    assign entry_s      = {data_r, parErr_r, frameErr_r, brk_s};

    // State register with registered Busy and the completion strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (fallEdge_s) stateNext_s = START;
                else            stateNext_s = IDLE;
            end
            START: begin
                if (tick_s && (thisTick_s == SAMPLE_MID) && sync2_r) stateNext_s = IDLE;
                else if (endTick_s)                                  stateNext_s = DATA;
                else                                                 stateNext_s = START;
            end
            DATA: begin
                if (endTick_s && lastBit_s) stateNext_s = parityOn_s ? PARITY : STOP;
                else                        stateNext_s = DATA;
            end
            PARITY: begin
                if (endTick_s) stateNext_s = STOP;
                else           stateNext_s = PARITY;
            end
            STOP: begin
                // Finish mid-stop so a back-to-back start edge is not missed.
                if (sampleTick_s && lastStop_s) stateNext_s = IDLE;
                else                            stateNext_s = STOP;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // Output decode: Busy covers confirmed frames only, done marks the final stop sample.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        if ((stateNext_s == DATA) || (stateNext_s == PARITY) || (stateNext_s == STOP)) busy_s = 1'b1;
        else                                                                              busy_s = 1'b0;
        if ((state_r == STOP) && sampleTick_s && lastStop_s) done_s = 1'b1;
        else                                                 done_s = 1'b0;
    end

    // Tick counting, majority sampling and frame assembly.
    always_ff @(posedge Clock) begin
        if (Reset || (state_r == IDLE && fallEdge_s)) begin
            cnt_r      <= 5'd0;
            bitIdx_r   <= 5'd0;
            stopIdx_r  <= 1'b0;
            v7_r       <= 1'b0;
            v8_r       <= 1'b0;
            data_r     <= '0;
            parAcc_r   <= 1'b0;
            anyOne_r   <= 1'b0;
            parErr_r   <= 1'b0;
            frameErr_r <= 1'b0;
            stop1Low_r <= 1'b0;
        end else if (tick_s && (state_r != IDLE)) begin
            cnt_r <= (thisTick_s == OVS) ? 5'd0 : thisTick_s;
            if (thisTick_s == SAMPLE_EARLY) v7_r <= sync2_r;
            if (thisTick_s == SAMPLE_MID)   v8_r <= sync2_r;
            if (thisTick_s == SAMPLE_LATE) begin
                case (state_r)
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (bitIdx_r == 5'(i)) data_r[i] <= maj_s;
                        end
                        parAcc_r <= parAcc_r ^ maj_s;
                        anyOne_r <= anyOne_r | maj_s;
                    end
                    PARITY: begin
                        parErr_r <= (ParityType == PAR_ODD) ? ~(parAcc_r ^ maj_s) : (parAcc_r ^ maj_s);
                        anyOne_r <= anyOne_r | maj_s;
                    end
                    STOP: begin
                        if (!maj_s)      frameErr_r <= 1'b1;
                        if (!stopIdx_r)  stop1Low_r <= ~maj_s;
                    end
                    default: ;
                endcase
            end
            if (thisTick_s == OVS) begin
                case (state_r)
                    DATA:    bitIdx_r  <= bitIdx_r + 5'd1;
                    STOP:    stopIdx_r <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_r, rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s, empty_s, push_s;

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign pop_s   = ~empty_s & DataReady;
    assign push_s  = done_r & (~full_s | pop_s);

    // Frame FIFO; a pop in the same cycle frees room for the completing frame.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            wrPtr_r   <= '0;
            rdPtr_r   <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= done_r & full_s & ~pop_s;
            if (push_s) begin
                mem_r[wrPtr_r] <= entry_s;
                wrPtr_r        <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) rdPtr_r <= rdPtr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign {DataOut, ParityErr, FrameErr, BreakFlag} = mem_r[rdPtr_r];
    assign DataValid = ~empty_s;
`else
    logic [ENT_W-1:0] hold_r;
    logic             holdValid_r;

    if (FIFO_DEPTH < 1) begin : gDepthUnused
    end

    assign pop_s = holdValid_r & DataReady;

    // Single holding register; new frame is dropped while the held one is unaccepted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_r      <= '0;
            holdValid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r <= done_r & holdValid_r & ~pop_s;
            if (done_r && (!holdValid_r || pop_s)) begin
                hold_r      <= entry_s;
                holdValid_r <= 1'b1;
            end else if (pop_s) begin
                holdValid_r <= 1'b0;
            end else begin
                holdValid_r <= holdValid_r;
            end
        end
    end

    assign {DataOut, ParityErr, FrameErr, BreakFlag} = hold_r;
    assign DataValid = holdValid_r;
`endif

    assign Overrun = overrun_r;
    assign Busy    = busy_r;

endmodule
